// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - bit-serial frame receiver with mid-bit sampling and valid/ready output
module serial_frame_rx #(
   parameter int DATA_W     = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_i,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              err_parity,
   output logic              err_frame,
   output logic              overrun,
   output logic              busy
);

   localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t            state_q;
   logic [1:0]        sync_q;
   logic [CW-1:0]     cnt_q;
   logic [IW-1:0]     idx_q;
   logic [DATA_W-1:0] shift_q;
   logic              par_err_q;
   logic              deliver_q;
   logic              err_parity_q;
   logic              err_frame_q;
   logic              overrun_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;

   logic rx_s;
   logic mid_start;
   logic bit_tick;

   assign rx_s      = sync_q[1];
   assign mid_start = (cnt_q == CW'(OVERSAMPLE / 2 - 1));
   assign bit_tick  = (cnt_q == CW'(OVERSAMPLE - 1));

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign err_parity = err_parity_q;
   assign err_frame  = err_frame_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != S_IDLE);

   // Two-flop synchronizer; resets to the idle-high line level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_i};
      end
   end

   // Frame FSM: bit timing, data shifting, parity/stop evaluation and error pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         par_err_q    <= 1'b0;
         deliver_q    <= 1'b0;
         err_parity_q <= 1'b0;
         err_frame_q  <= 1'b0;
      end else begin
         deliver_q    <= 1'b0;
         err_parity_q <= 1'b0;
         err_frame_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  state_q   <= S_START;
                  cnt_q     <= '0;
                  par_err_q <= 1'b0;
               end
            end
            S_START: begin
               if (mid_start) begin
                  cnt_q <= '0;
                  idx_q <= '0;
                  // A line that is high again at mid-start was only a glitch
                  state_q <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DATA: begin
               if (bit_tick) begin
                  cnt_q          <= '0;
                  shift_q[idx_q] <= rx_s;
                  if (idx_q == IW'(DATA_W - 1)) begin
                     state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_PARITY: begin
               if (bit_tick) begin
                  cnt_q     <= '0;
                  par_err_q <= (rx_s != ^shift_q);
                  state_q   <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_STOP: begin
               if (bit_tick) begin
                  cnt_q <= '0;
                  // Framing error outranks parity; the line must return high before re-arming
                  if (!rx_s) begin
                     err_frame_q <= 1'b1;
                     state_q     <= S_BREAK;
                  end else if (par_err_q) begin
                     err_parity_q <= 1'b1;
                     state_q      <= S_IDLE;
                  end else begin
                     deliver_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_BREAK: begin
               if (rx_s) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Output holding register: load a finished word when the slot is free, else flag overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         overrun_q   <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (deliver_q) begin
            if (!out_valid_q || out_ready) begin
               out_data_q  <= shift_q;
               out_valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule
